// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy fire scheduler: FSM states, screen
// geometry and the bullet launch offset helper.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_ARB      = 2'd2,
        ST_FLIGHT   = 2'd3
    } state_t;

    localparam logic [9:0] screen_w   = 10'd640;
    localparam logic [9:0] screen_bot = 10'd479;
    localparam logic [9:0] ship_w     = 10'd40;

    // Bullets leave from the horizontal centre of the firing ship.
    function automatic logic [9:0] launch_x(input logic [9:0] left);
        return left + (ship_w >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted column and wraps, so every live column gets its turn.
module rr_arbiter #(
    parameter int num_cols_p = 8
) (
    input  logic [num_cols_p-1:0]         req,
    input  logic [$clog2(num_cols_p)-1:0] last_grant,
    output logic [num_cols_p-1:0]         grant,
    output logic [$clog2(num_cols_p)-1:0] grant_idx,
    output logic                          any_grant
);

    localparam int idx_w = $clog2(num_cols_p);

    int cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int i = 1; i <= num_cols_p; i++) begin
            cand = (int'(last_grant) + i) % num_cols_p;
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = idx_w'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Schedules enemy shots: waits fire_delay_p frames, picks a shooter column
// round-robin, then flies a single bullet down until it hits or leaves.
module enemy_fire_scheduler
    import enemy_pkg::*;
#(
    parameter int         num_cols_p    = 8,
    parameter int         fire_delay_p  = 60,
    parameter int         bullet_step_p = 4,
    parameter logic [9:0] screen_bot_p  = screen_bot
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          frame_i,
    input  logic                          enable_i,
    input  logic [num_cols_p-1:0]         req_i,
    input  logic [10*num_cols_p-1:0]      col_left_i,
    input  logic [10*num_cols_p-1:0]      col_bot_i,
    input  logic                          hit_i,
    output logic                          bullet_valid_o,
    output logic [9:0]                    bullet_x_o,
    output logic [9:0]                    bullet_y_o,
    output logic [$clog2(num_cols_p)-1:0] shooter_o,
    output logic                          fire_o,
    output logic [1:0]                    state_o
);

    localparam int idx_w = $clog2(num_cols_p);
    localparam int cnt_w = $clog2(fire_delay_p + 1);

    state_t                  state;
    logic [cnt_w-1:0]        frame_cnt;
    logic [num_cols_p-1:0]   grant;
    logic [idx_w-1:0]        grant_idx;
    logic                    any_grant;
    logic [9:0]              sel_left;
    logic [9:0]              sel_bot;
    logic [10:0]             next_y_wide;
    logic                    off_screen;
    logic                    last_frame;

    rr_arbiter #(
        .num_cols_p(num_cols_p)
    ) u_arb (
        .req       (req_i),
        .last_grant(shooter_o),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    always_comb begin
        sel_left = '0;
        sel_bot  = '0;
        for (int c = 0; c < num_cols_p; c++) begin
            if (grant[c]) begin
                sel_left = col_left_i[10*c +: 10];
                sel_bot  = col_bot_i[10*c +: 10];
            end
        end
    end

    // One extra bit so a bullet near the bottom can never wrap back to the top.
    assign next_y_wide = {1'b0, bullet_y_o} + 11'(bullet_step_p);
    assign off_screen  = next_y_wide > {1'b0, screen_bot_p};
    assign last_frame  = frame_cnt == cnt_w'(fire_delay_p - 1);
    assign state_o     = state;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= ST_IDLE;
            frame_cnt      <= '0;
            bullet_valid_o <= 1'b0;
            fire_o         <= 1'b0;
            bullet_x_o     <= '0;
            bullet_y_o     <= '0;
            shooter_o      <= idx_w'(num_cols_p - 1);
        end else begin
            fire_o <= 1'b0;
            if (!enable_i) begin
                state          <= ST_IDLE;
                frame_cnt      <= '0;
                bullet_valid_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_COOLDOWN;
                        frame_cnt <= '0;
                    end
                    ST_COOLDOWN: begin
                        if (frame_i) begin
                            if (last_frame) begin
                                state     <= ST_ARB;
                                frame_cnt <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    ST_ARB: begin
                        frame_cnt <= '0;
                        if (any_grant) begin
                            bullet_x_o     <= launch_x(sel_left);
                            bullet_y_o     <= sel_bot;
                            shooter_o      <= grant_idx;
                            fire_o         <= 1'b1;
                            bullet_valid_o <= 1'b1;
                            state          <= ST_FLIGHT;
                        end else begin
                            state <= ST_COOLDOWN;
                        end
                    end
                    ST_FLIGHT: begin
                        // A collision wins over movement in the same cycle.
                        if (hit_i) begin
                            state          <= ST_COOLDOWN;
                            frame_cnt      <= '0;
                            bullet_valid_o <= 1'b0;
                        end else if (frame_i) begin
                            if (off_screen) begin
                                state          <= ST_COOLDOWN;
                                frame_cnt      <= '0;
                                bullet_valid_o <= 1'b0;
                            end else begin
                                bullet_y_o <= next_y_wide[9:0];
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
